// File: rtl/controladora_multiciclo_pkg.sv
// Shared definitions for the multicycle MIPS control unit:
// opcodes, state encoding, ULA operation codes and datapath mux selects.
package controladora_multiciclo_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        WB_R     = 4'd3,
        EXEC_I   = 4'd4,
        WB_I     = 4'd5,
        MEM_ADDR = 4'd6,
        MEM_RD   = 4'd7,
        MEM_WR   = 4'd8,
        WB_MEM   = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        TRAP     = 4'd12
    } estado_t;

    typedef enum logic [2:0] {
        CL_R   = 3'd0,
        CL_I   = 3'd1,
        CL_MEM = 3'd2,
        CL_BR  = 3'd3,
        CL_JMP = 3'd4
    } classe_t;

    localparam logic [2:0] ULA_FUNCT = 3'b000;
    localparam logic [2:0] ULA_LUI   = 3'b001;
    localparam logic [2:0] ULA_SUB   = 3'b010;
    localparam logic [2:0] ULA_ADD   = 3'b100;
    localparam logic [2:0] ULA_AND   = 3'b101;
    localparam logic [2:0] ULA_OR    = 3'b110;
    localparam logic [2:0] ULA_XOR   = 3'b111;

    localparam logic [1:0] PC_ULA    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] B_REG  = 2'b00;
    localparam logic [1:0] B_4    = 2'b01;
    localparam logic [1:0] B_IMM  = 2'b10;
    localparam logic [1:0] B_IMM2 = 2'b11;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] MPR_ALU = 2'b00;
    localparam logic [1:0] MPR_MDR = 2'b01;
    localparam logic [1:0] MPR_PC  = 2'b10;

endpackage

// File: rtl/controladora_multiciclo_classifica_opcode.sv
// Opcode classifier: instruction class, immediate ULA operation
// and a validity flag used to divert unknown opcodes to TRAP.
module classifica_opcode
    import controladora_multiciclo_pkg::*;
(
    input  logic [5:0] Op,
    output classe_t    classe,
    output logic [2:0] OpULA_I,
    output logic       valido
);

    always_comb begin
        classe  = CL_R;
        OpULA_I = ULA_ADD;
        valido  = 1'b1;
        unique case (Op)
            OP_R:    classe = CL_R;
            OP_LUI:  begin classe = CL_I; OpULA_I = ULA_LUI; end
            OP_ADDI: begin classe = CL_I; OpULA_I = ULA_ADD; end
            OP_ANDI: begin classe = CL_I; OpULA_I = ULA_AND; end
            OP_ORI:  begin classe = CL_I; OpULA_I = ULA_OR;  end
            OP_XORI: begin classe = CL_I; OpULA_I = ULA_XOR; end
            OP_LW,
            OP_SW:   classe = CL_MEM;
            OP_BEQ,
            OP_BNE:  classe = CL_BR;
            OP_J,
            OP_JAL:  classe = CL_JMP;
            default: valido = 1'b0;
        endcase
    end

endmodule

// File: rtl/controladora_multiciclo.sv
// Multicycle MIPS control FSM: sequences the shared ULA, the shared
// memory (mem_req/mem_ready handshake) and the datapath registers.
module controladora_multiciclo
    import controladora_multiciclo_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       IouD,
    output logic       EscreveMem,
    output logic       EscreveIR,
    output logic       EscreveMDR,
    output logic       EscrevePC,
    output logic [1:0] OrigPC,
    output logic       OrigUlaA,
    output logic [1:0] OrigUlaB,
    output logic [2:0] OpULA,
    output logic       EscreveReg,
    output logic [1:0] RegDst,
    output logic [1:0] MemparaReg,
    output logic       UnknownOpcode,
    output logic [3:0] estado
);

    estado_t    st, nx;
    classe_t    classe;
    logic [2:0] opula_i;
    logic       valido;
    logic       unk;

    classifica_opcode u_classifica (
        .Op      (Op),
        .classe  (classe),
        .OpULA_I (opula_i),
        .valido  (valido)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st  <= FETCH;
            unk <= 1'b0;
        end else begin
            st <= nx;
            if (nx == TRAP)
                unk <= 1'b1;
        end
    end

    assign estado = st;

    always_comb begin
        nx = st;
        unique case (st)
            FETCH:    if (mem_ready) nx = DECODE;
            DECODE: begin
                if (!valido) begin
                    nx = TRAP;
                end else begin
                    unique case (classe)
                        CL_R:    nx = EXEC_R;
                        CL_I:    nx = EXEC_I;
                        CL_MEM:  nx = MEM_ADDR;
                        CL_BR:   nx = BRANCH;
                        CL_JMP:  nx = JUMP;
                        default: nx = TRAP;
                    endcase
                end
            end
            EXEC_R:   nx = WB_R;
            WB_R:     nx = FETCH;
            EXEC_I:   nx = WB_I;
            WB_I:     nx = FETCH;
            MEM_ADDR: nx = (Op == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD:   if (mem_ready) nx = WB_MEM;
            MEM_WR:   if (mem_ready) nx = FETCH;
            WB_MEM:   nx = FETCH;
            BRANCH:   nx = FETCH;
            JUMP:     nx = FETCH;
            TRAP:     nx = TRAP;
            default:  nx = FETCH;
        endcase
    end

    always_comb begin
        mem_req       = 1'b0;
        IouD          = 1'b0;
        EscreveMem    = 1'b0;
        EscreveIR     = 1'b0;
        EscreveMDR    = 1'b0;
        EscrevePC     = 1'b0;
        OrigPC        = PC_ULA;
        OrigUlaA      = 1'b0;
        OrigUlaB      = B_REG;
        OpULA         = ULA_FUNCT;
        EscreveReg    = 1'b0;
        RegDst        = DST_RT;
        MemparaReg    = MPR_ALU;
        UnknownOpcode = unk;
        unique case (st)
            FETCH: begin
                mem_req   = 1'b1;
                OrigUlaB  = B_4;
                OpULA     = ULA_ADD;
                EscreveIR = mem_ready;
                EscrevePC = mem_ready;
            end
            DECODE: begin
                OrigUlaB = B_IMM2;
                OpULA    = ULA_ADD;
            end
            EXEC_R: begin
                OrigUlaA = 1'b1;
                OpULA    = ULA_FUNCT;
            end
            WB_R: begin
                EscreveReg = 1'b1;
                RegDst     = DST_RD;
            end
            EXEC_I: begin
                OrigUlaA = 1'b1;
                OrigUlaB = B_IMM;
                OpULA    = opula_i;
            end
            WB_I:     EscreveReg = 1'b1;
            MEM_ADDR: begin
                OrigUlaA = 1'b1;
                OrigUlaB = B_IMM;
                OpULA    = ULA_ADD;
            end
            MEM_RD: begin
                mem_req    = 1'b1;
                IouD       = 1'b1;
                EscreveMDR = mem_ready;
            end
            MEM_WR: begin
                mem_req    = 1'b1;
                IouD       = 1'b1;
                EscreveMem = 1'b1;
            end
            WB_MEM: begin
                EscreveReg = 1'b1;
                MemparaReg = MPR_MDR;
            end
            BRANCH: begin
                OrigUlaA  = 1'b1;
                OpULA     = ULA_SUB;
                OrigPC    = PC_ALUOUT;
                EscrevePC = ((Op == OP_BEQ) & Zero)
                          | ((Op == OP_BNE) & ~Zero);
            end
            JUMP: begin
                EscrevePC = 1'b1;
                OrigPC    = PC_JUMP;
                if (Op == OP_JAL) begin
                    EscreveReg = 1'b1;
                    RegDst     = DST_RA;
                    MemparaReg = MPR_PC;
                end
            end
            default: ;
        endcase
        // Reset also kills any in-flight memory access this same cycle
        if (!rst_n) begin
            mem_req       = 1'b0;
            IouD          = 1'b0;
            EscreveMem    = 1'b0;
            EscreveIR     = 1'b0;
            EscreveMDR    = 1'b0;
            EscrevePC     = 1'b0;
            OrigPC        = 2'b00;
            OrigUlaA      = 1'b0;
            OrigUlaB      = 2'b00;
            OpULA         = 3'b000;
            EscreveReg    = 1'b0;
            RegDst        = 2'b00;
            MemparaReg    = 2'b00;
            UnknownOpcode = 1'b0;
        end
    end

endmodule

// File: tb/tb_controladora_multiciclo.sv
// Self-checking bench for controladora_multiciclo: per-cycle expected
// state and control word are queued when inputs are driven, then popped.
module tb_controladora_multiciclo;

    localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1;
    localparam logic [3:0] S_EXEC_R = 4'd2, S_WB_R = 4'd3;
    localparam logic [3:0] S_EXEC_I = 4'd4, S_WB_I = 4'd5;
    localparam logic [3:0] S_MADDR = 4'd6,  S_MRD = 4'd7;
    localparam logic [3:0] S_MWR = 4'd8,    S_WBM = 4'd9;
    localparam logic [3:0] S_BR = 4'd10,    S_JMP = 4'd11;
    localparam logic [3:0] S_TRAP = 4'd12;

    localparam logic [5:0] O_R = 6'h00, O_J = 6'h02, O_JAL = 6'h03;
    localparam logic [5:0] O_BEQ = 6'h04, O_BNE = 6'h05;
    localparam logic [5:0] O_ADDI = 6'h08, O_ANDI = 6'h0C;
    localparam logic [5:0] O_ORI = 6'h0D, O_XORI = 6'h0E;
    localparam logic [5:0] O_LUI = 6'h0F, O_LW = 6'h23, O_SW = 6'h2B;

    typedef struct packed {
        logic       req, iou, wmem, wir, wmdr, wpc;
        logic [1:0] opc;
        logic       a;
        logic [1:0] b;
        logic [2:0] ula;
        logic       wreg;
        logic [1:0] dst, mpr;
        logic       unk;
    } ctl_t;

    typedef struct packed {
        logic [3:0] st;
        ctl_t       c;
    } exp_t;

    typedef struct packed {
        logic [3:0] st;
        logic       z;
        logic       r;
    } row_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] Op;
    logic       Zero, mem_ready;
    logic       mem_req, IouD, EscreveMem, EscreveIR, EscreveMDR, EscrevePC;
    logic [1:0] OrigPC, OrigUlaB, RegDst, MemparaReg;
    logic       OrigUlaA, EscreveReg, UnknownOpcode;
    logic [2:0] OpULA;
    logic [3:0] estado;
    ctl_t       act;

    exp_t exp_q[$];
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    controladora_multiciclo dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .Zero(Zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .IouD(IouD),
        .EscreveMem(EscreveMem), .EscreveIR(EscreveIR),
        .EscreveMDR(EscreveMDR), .EscrevePC(EscrevePC),
        .OrigPC(OrigPC), .OrigUlaA(OrigUlaA), .OrigUlaB(OrigUlaB),
        .OpULA(OpULA), .EscreveReg(EscreveReg), .RegDst(RegDst),
        .MemparaReg(MemparaReg), .UnknownOpcode(UnknownOpcode),
        .estado(estado)
    );

    assign act = {mem_req, IouD, EscreveMem, EscreveIR, EscreveMDR,
                  EscrevePC, OrigPC, OrigUlaA, OrigUlaB, OpULA,
                  EscreveReg, RegDst, MemparaReg, UnknownOpcode};

    function automatic ctl_t ref_ctl(logic [3:0] s, logic [5:0] op,
                                     logic z, logic r);
        ctl_t c = '0;
        case (s)
            S_FETCH:  begin c.req = 1; c.b = 2'b01; c.ula = 3'b100;
                            c.wir = r; c.wpc = r; end
            S_DECODE: begin c.b = 2'b11; c.ula = 3'b100; end
            S_EXEC_R: begin c.a = 1; c.b = 2'b00; c.ula = 3'b000; end
            S_WB_R:   begin c.wreg = 1; c.dst = 2'b01; end
            S_EXEC_I: begin
                c.a = 1; c.b = 2'b10;
                case (op)
                    O_LUI:   c.ula = 3'b001;
                    O_ADDI:  c.ula = 3'b100;
                    O_ANDI:  c.ula = 3'b101;
                    O_ORI:   c.ula = 3'b110;
                    default: c.ula = 3'b111;
                endcase
            end
            S_WB_I:   c.wreg = 1;
            S_MADDR:  begin c.a = 1; c.b = 2'b10; c.ula = 3'b100; end
            S_MRD:    begin c.req = 1; c.iou = 1; c.wmdr = r; end
            S_MWR:    begin c.req = 1; c.iou = 1; c.wmem = 1; end
            S_WBM:    begin c.wreg = 1; c.mpr = 2'b01; end
            S_BR: begin
                c.a = 1; c.ula = 3'b010; c.opc = 2'b01;
                c.wpc = (op == O_BEQ && z) || (op == O_BNE && !z);
            end
            S_JMP: begin
                c.wpc = 1; c.opc = 2'b10;
                if (op == O_JAL) begin
                    c.wreg = 1; c.dst = 2'b10; c.mpr = 2'b10;
                end
            end
            S_TRAP:   c.unk = 1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    task automatic apply(input row_t rw);
        exp_t e;
        Zero      = rw.z;
        mem_ready = rw.r;
        e.st = rw.st;
        e.c  = ref_ctl(rw.st, Op, rw.z, rw.r);
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; Op = O_R; Zero = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        #1;
        nvec++;
        if (estado !== S_FETCH || act !== '0) begin
            nerr++;
            $display("FAIL reset: estado=%0d ctl=%h want estado=0 ctl=0",
                     estado, act);
        end
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b0;
        #1;
        nvec++;
        if (estado !== S_FETCH || UnknownOpcode !== 1'b0) begin
            nerr++;
            $display("FAIL reset_rel: estado=%0d unk=%b want 0/0",
                     estado, UnknownOpcode);
        end
        @(negedge clk);
    endtask

    task automatic test_lui();
        row_t rw [5] = '{'{S_FETCH, 1'b0, 1'b1}, '{S_DECODE, 1'b0, 1'b1},
                         '{S_EXEC_I, 1'b0, 1'b1}, '{S_WB_I, 1'b0, 1'b1},
                         '{S_FETCH, 1'b0, 1'b0}};
        exp_t e;
        Op = O_LUI;
        for (int i = 0; i < 5; i++) begin
            apply(rw[i]);
            #1;
            e = exp_q.pop_front();
            nvec++;
            if (estado !== e.st || act !== e.c) begin
                nerr++;
                $display("FAIL lui[%0d]: estado=%0d ctl=%h want %0d/%h",
                         i, estado, act, e.st, e.c);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_itype_rtype();
        logic [5:0] ops [5] = '{O_ADDI, O_ANDI, O_ORI, O_XORI, O_R};
        exp_t e;
        row_t rw [6];
        for (int k = 0; k < 5; k++) begin
            Op = ops[k];
            rw[0] = '{S_FETCH, 1'b0, 1'b0};
            rw[1] = '{S_FETCH, 1'b1, 1'b1};
            rw[2] = '{S_DECODE, 1'b0, 1'b1};
            rw[3] = (k == 4) ? row_t'{S_EXEC_R, 1'b0, 1'b1}
                             : row_t'{S_EXEC_I, 1'b0, 1'b1};
            rw[4] = (k == 4) ? row_t'{S_WB_R, 1'b0, 1'b1}
                             : row_t'{S_WB_I, 1'b0, 1'b1};
            rw[5] = '{S_FETCH, 1'b0, 1'b0};
            for (int i = 0; i < 6; i++) begin
                apply(rw[i]);
                #1;
                e = exp_q.pop_front();
                nvec++;
                if (estado !== e.st || act !== e.c) begin
                    nerr++;
                    $display("FAIL op%h[%0d]: estado=%0d ctl=%h want %0d/%h",
                             Op, i, estado, act, e.st, e.c);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_lw_wait();
        row_t rw [8] = '{'{S_FETCH, 1'b0, 1'b1}, '{S_DECODE, 1'b0, 1'b0},
                         '{S_MADDR, 1'b0, 1'b0}, '{S_MRD, 1'b0, 1'b0},
                         '{S_MRD, 1'b0, 1'b0}, '{S_MRD, 1'b0, 1'b1},
                         '{S_WBM, 1'b0, 1'b1}, '{S_FETCH, 1'b0, 1'b0}};
        exp_t e;
        int   mdr = 0;
        Op = O_LW;
        for (int i = 0; i < 8; i++) begin
            apply(rw[i]);
            #1;
            e = exp_q.pop_front();
            nvec++;
            if (EscreveMDR === 1'b1) mdr++;
            if (estado !== e.st || act !== e.c) begin
                nerr++;
                $display("FAIL lw[%0d]: estado=%0d ctl=%h want %0d/%h",
                         i, estado, act, e.st, e.c);
            end
            @(negedge clk);
        end
        nvec++;
        if (mdr != 1) begin
            nerr++;
            $display("FAIL lw_mdr_pulses: got %0d want 1", mdr);
        end
    endtask

    task automatic test_sw();
        row_t rw [6] = '{'{S_FETCH, 1'b0, 1'b1}, '{S_DECODE, 1'b0, 1'b1},
                         '{S_MADDR, 1'b0, 1'b1}, '{S_MWR, 1'b0, 1'b0},
                         '{S_MWR, 1'b0, 1'b1}, '{S_FETCH, 1'b0, 1'b0}};
        exp_t e;
        Op = O_SW;
        for (int i = 0; i < 6; i++) begin
            apply(rw[i]);
            #1;
            e = exp_q.pop_front();
            nvec++;
            if (estado !== e.st || act !== e.c) begin
                nerr++;
                $display("FAIL sw[%0d]: estado=%0d ctl=%h want %0d/%h",
                         i, estado, act, e.st, e.c);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        exp_t e;
        row_t rw [4];
        for (int k = 0; k < 4; k++) begin
            Op = k[1] ? O_BNE : O_BEQ;
            rw[0] = '{S_FETCH, 1'b0, 1'b1};
            rw[1] = '{S_DECODE, 1'b0, 1'b0};
            rw[2] = '{S_BR, k[0], 1'b1};
            rw[3] = '{S_FETCH, 1'b0, 1'b0};
            for (int i = 0; i < 4; i++) begin
                apply(rw[i]);
                #1;
                e = exp_q.pop_front();
                nvec++;
                if (estado !== e.st || act !== e.c) begin
                    nerr++;
                    $display("FAIL br%0d[%0d]: estado=%0d ctl=%h want %0d/%h",
                             k, i, estado, act, e.st, e.c);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_jump();
        exp_t e;
        row_t rw [4] = '{'{S_FETCH, 1'b0, 1'b1}, '{S_DECODE, 1'b0, 1'b0},
                         '{S_JMP, 1'b0, 1'b1}, '{S_FETCH, 1'b0, 1'b0}};
        for (int k = 0; k < 2; k++) begin
            Op = (k == 0) ? O_J : O_JAL;
            for (int i = 0; i < 4; i++) begin
                apply(rw[i]);
                #1;
                e = exp_q.pop_front();
                nvec++;
                if (estado !== e.st || act !== e.c) begin
                    nerr++;
                    $display("FAIL jmp%0d[%0d]: estado=%0d ctl=%h want %0d/%h",
                             k, i, estado, act, e.st, e.c);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_trap();
        exp_t e;
        row_t rw;
        Op = 6'b111111;
        for (int i = 0; i < 14; i++) begin
            if (i == 0)      rw = '{S_FETCH, 1'b0, 1'b1};
            else if (i == 1) rw = '{S_DECODE, 1'b0, 1'b0};
            else             rw = '{S_TRAP, i[0], i[1]};
            apply(rw);
            #1;
            e = exp_q.pop_front();
            nvec++;
            if (estado !== e.st || act !== e.c) begin
                nerr++;
                $display("FAIL trap[%0d]: estado=%0d ctl=%h want %0d/%h",
                         i, estado, act, e.st, e.c);
            end
            @(negedge clk);
        end
        rst_n = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b0; Op = O_R;
        #1;
        nvec++;
        if (estado !== S_FETCH || UnknownOpcode !== 1'b0) begin
            nerr++;
            $display("FAIL trap_clear: estado=%0d unk=%b want 0/0",
                     estado, UnknownOpcode);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        exp_t e;
        row_t rw [4] = '{'{S_FETCH, 1'b0, 1'b1}, '{S_DECODE, 1'b0, 1'b1},
                         '{S_MADDR, 1'b0, 1'b1}, '{S_MWR, 1'b0, 1'b0}};
        Op = O_SW;
        for (int i = 0; i < 4; i++) begin
            apply(rw[i]);
            #1;
            e = exp_q.pop_front();
            nvec++;
            if (estado !== e.st || act !== e.c) begin
                nerr++;
                $display("FAIL rstwr[%0d]: estado=%0d ctl=%h want %0d/%h",
                         i, estado, act, e.st, e.c);
            end
            @(negedge clk);
        end
        rst_n = 1'b0; mem_ready = 1'b0;
        #1;
        nvec++;
        if (estado !== S_MWR || mem_req !== 1'b0 || EscreveMem !== 1'b0) begin
            nerr++;
            $display("FAIL rstwr_hold: estado=%0d req=%b wmem=%b want 8/0/0",
                     estado, mem_req, EscreveMem);
        end
        @(negedge clk);
        #1;
        nvec++;
        if (estado !== S_FETCH || act !== '0) begin
            nerr++;
            $display("FAIL rstwr_after: estado=%0d ctl=%h want 0/0",
                     estado, act);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lui();
        test_itype_rtype();
        test_lw_wait();
        test_sw();
        test_branch();
        test_jump();
        test_trap();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
